// File: rtl/calc_display_scheduler.sv
// calc_display_scheduler: arbitrates the keypad-entry and ALU-result paths
// for the four-digit display, converts the granted binary value to BCD with a
// sequential shift-add-3 engine, then applies leading-zero blanking or the
// overflow glyph and holds the digits until the next update.
//
// Handshake: a requester raises its Req with a stable Value and holds both
// until its Ack pulses for one cycle, meaning the Value has been captured.
// Requests seen while Busy are left pending and are served from IDLE, with the
// result path winning when both are pending.
module calc_display_scheduler #(
    parameter int         WIDTH = 14,
    parameter logic [3:0] BLANK = 4'hF,
    parameter logic [3:0] ERR   = 4'hE
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             EntryReq,
    input  logic [WIDTH-1:0] EntryValue,
    output logic             EntryAck,
    input  logic             ResultReq,
    input  logic [WIDTH-1:0] ResultValue,
    output logic             ResultAck,
    output logic             Busy,
    output logic             Source,
    output logic [3:0]       BCD3,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD0,
    output logic [1:0]       fsm_state
);

    localparam int DIGITS = 5;
    localparam int BCDW   = 4 * DIGITS;
    localparam int SHW    = BCDW + WIDTH;
    localparam int CW     = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SHW-1:0]   shreg;
    logic [SHW-1:0]   adj;
    logic [CW-1:0]    iter;
    logic             ovf;
    logic             pend_src;
    logic [WIDTH-1:0] cap_value;
    logic             cap_ovf;
    logic [15:0]      low_bcd;

    assign fsm_state = state;
    assign Busy      = (state != IDLE);

    // Value that IDLE would capture this cycle, with the result path winning.
    always_comb begin
        cap_value = ResultReq ? ResultValue : EntryValue;
        cap_ovf   = ({{(32-WIDTH){1'b0}}, cap_value} > 32'd9999);
    end

    // Shift-add-3 correction: every BCD nibble of 5 or more gets 3 added.
    always_comb begin
        adj = shreg;
        for (int i = 0; i < DIGITS; i++) begin
            if (shreg[WIDTH+4*i +: 4] >= 4'd5)
                adj[WIDTH+4*i +: 4] = shreg[WIDTH+4*i +: 4] + 4'd3;
        end
    end

    // The four displayed digits sit just above the binary field once done.
    assign low_bcd = shreg[WIDTH +: 16];

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: grant from IDLE, WIDTH shifts, one update cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ResultReq || EntryReq) state_next = CONVERT;
            CONVERT: if (iter == CW'(WIDTH - 1)) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture and ack, shift engine, and the held display outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            EntryAck  <= 1'b0;
            ResultAck <= 1'b0;
            shreg     <= '0;
            iter      <= '0;
            ovf       <= 1'b0;
            pend_src  <= 1'b0;
            Source    <= 1'b0;
            BCD3      <= BLANK;
            BCD2      <= BLANK;
            BCD1      <= BLANK;
            BCD0      <= 4'h0;
        end else begin
            EntryAck  <= 1'b0;
            ResultAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (ResultReq || EntryReq) begin
                        ResultAck <= ResultReq;
                        EntryAck  <= !ResultReq;
                        pend_src  <= ResultReq;
                        shreg     <= {{BCDW{1'b0}}, cap_value};
                        ovf       <= cap_ovf;
                        iter      <= '0;
                    end
                end
                CONVERT: begin
                    shreg <= adj << 1;
                    iter  <= iter + 1'b1;
                end
                UPDATE: begin
                    Source <= pend_src;
                    if (ovf) begin
                        BCD3 <= ERR;
                        BCD2 <= ERR;
                        BCD1 <= ERR;
                        BCD0 <= ERR;
                    end else begin
                        BCD3 <= (low_bcd[15:12] == 4'd0) ? BLANK : low_bcd[15:12];
                        BCD2 <= (low_bcd[15:8] == 8'd0) ? BLANK : low_bcd[11:8];
                        BCD1 <= (low_bcd[15:4] == 12'd0) ? BLANK : low_bcd[7:4];
                        BCD0 <= low_bcd[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_display_scheduler.sv
// Bench for calc_display_scheduler: directed cases plus random transactions,
// compared against a decimal-arithmetic model of the display contents.
module tb_calc_display_scheduler;

  localparam int WIDTH = 14;

  logic             clk;
  logic             reset;
  logic             entry_req;
  logic [WIDTH-1:0] entry_value;
  logic             entry_ack;
  logic             result_req;
  logic [WIDTH-1:0] result_value;
  logic             result_ack;
  logic             busy;
  logic             source;
  logic [3:0]       bcd3, bcd2, bcd1, bcd0;
  logic [1:0]       fsm_state;

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] exp_q[$];
  logic [16:0] disp_exp;

  calc_display_scheduler #(.WIDTH(WIDTH)) dut (
    .Clk         (clk),
    .Reset       (reset),
    .EntryReq    (entry_req),
    .EntryValue  (entry_value),
    .EntryAck    (entry_ack),
    .ResultReq   (result_req),
    .ResultValue (result_value),
    .ResultAck   (result_ack),
    .Busy        (busy),
    .Source      (source),
    .BCD3        (bcd3),
    .BCD2        (bcd2),
    .BCD1        (bcd1),
    .BCD0        (bcd0),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Display expected for a value: decimal digits, blanked by magnitude.
  function automatic logic [15:0] model_digits(input int v);
    int d3, d2, d1, d0;
    if (v > 9999) return 16'hEEEE;
    d3 = v / 1000;
    d2 = (v / 100) % 10;
    d1 = (v / 10) % 10;
    d0 = v % 10;
    if (v < 1000) d3 = 15;
    if (v < 100)  d2 = 15;
    if (v < 10)   d1 = 15;
    return {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  function automatic logic [15:0] shown();
    return {bcd3, bcd2, bcd1, bcd0};
  endfunction

  // driver tasks
  task automatic start_req(input bit src, input int v);
    @(posedge clk);
    #1;
    if (src) begin
      result_req   = 1'b1;
      result_value = WIDTH'(v);
    end else begin
      entry_req   = 1'b1;
      entry_value = WIDTH'(v);
    end
  endtask

  // Waits (bounded) for the Ack of src, then follows the whole conversion
  // timeline and compares the resulting display against the model.
  task automatic finish_txn(input bit src, input int v, input int exp_wait);
    int  waited;
    bit  got;
    logic [16:0] exp_item;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 40) begin
      @(negedge clk);
      waited++;
      got = src ? result_ack : entry_ack;
    end
    check("ack_seen", 32'(got), 32'd1);
    if (!got) begin
      @(posedge clk);
      #1;
      if (src) result_req = 1'b0; else entry_req = 1'b0;
      return;
    end
    check("ack_latency", 32'(waited), 32'(exp_wait));
    exp_q.push_back({src, model_digits(v)});
    check("busy_c1", 32'(busy), 32'd1);
    check("other_ack_c1", 32'(src ? entry_ack : result_ack), 32'd0);
    @(posedge clk);
    #1;
    if (src) result_req = 1'b0; else entry_req = 1'b0;
    for (int c = 2; c <= 15; c++) begin
      @(negedge clk);
      check("busy_conv", 32'(busy), 32'd1);
      if (c == 2) check("ack_one_cycle", 32'(src ? result_ack : entry_ack), 32'd0);
      if (c == 15) begin
        check("digits_held", 32'(shown()), 32'(disp_exp[15:0]));
        check("source_held", 32'(source), 32'(disp_exp[16]));
      end
    end
    @(negedge clk);
    exp_item = exp_q.pop_front();
    check("busy_done", 32'(busy), 32'd0);
    check("digits", 32'(shown()), 32'(exp_item[15:0]));
    check("source", 32'(source), 32'(exp_item[16]));
    disp_exp = exp_item;
  endtask

  task automatic run_txn(input bit src, input int v);
    start_req(src, v);
    finish_txn(src, v, 2);
  endtask

  initial begin
    int  waited;
    bit  any_ack;
    bit  src;
    int  v;

    reset        = 1'b1;
    entry_req    = 1'b0;
    entry_value  = '0;
    result_req   = 1'b0;
    result_value = '0;
    disp_exp     = {1'b0, 16'hFFF0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state, then idle
    repeat (3) @(negedge clk);
    check("rst_digits", 32'(shown()), 32'hFFF0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_entry_ack", 32'(entry_ack), 32'd0);
    check("rst_result_ack", 32'(result_ack), 32'd0);
    check("rst_source", 32'(source), 32'd0);

    // reset wins over a request on the same edge
    @(posedge clk);
    #1;
    reset       = 1'b1;
    entry_req   = 1'b1;
    entry_value = WIDTH'(7);
    @(negedge clk);
    @(negedge clk);
    check("rst_prio_ack", 32'(entry_ack), 32'd0);
    check("rst_prio_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    finish_txn(1'b0, 7, 2);

    // directed cases
    run_txn(1'b1, 1234);
    run_txn(1'b0, 0);
    run_txn(1'b0, 105);
    run_txn(1'b1, 10000);
    run_txn(1'b1, 16383);
    run_txn(1'b0, 9999);
    run_txn(1'b0, 10);
    run_txn(1'b1, 1000);

    // simultaneous requests: result first, entry on the next IDLE edge
    @(posedge clk);
    #1;
    entry_req    = 1'b1;
    entry_value  = WIDTH'(42);
    result_req   = 1'b1;
    result_value = WIDTH'(9999);
    finish_txn(1'b1, 9999, 2);
    finish_txn(1'b0, 42, 1);

    // reset five cycles into a conversion aborts it
    start_req(1'b1, 5678);
    waited = 0;
    while (!result_ack && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("abort_ack_seen", 32'(result_ack), 32'd1);
    @(posedge clk);
    #1 result_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_digits", 32'(shown()), 32'hFFF0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_source", 32'(source), 32'd0);
    disp_exp = {1'b0, 16'hFFF0};
    any_ack  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (entry_ack || result_ack || busy) any_ack = 1'b1;
    end
    check("abort_no_ack", 32'(any_ack), 32'd0);
    run_txn(1'b1, 5678);

    // random transactions
    for (int n = 0; n < 30; n++) begin
      src = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, 16383);
      endcase
      run_txn(src, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
